arm7tdmi_cp15: RTL

System-control coprocessor (CP15) responder on the core's coprocessor interface. Accepts MRC/MCR/CDP/LDC/STC requests issued from the decode/execute path, and answers each with absent, busy or done. Holds the ID, control, translation-base and domain registers, and drives their configuration bits to the MMU/cache/vector logic. Sits beside the execute stage as the p15 endpoint.

---
 rtl/arm7tdmi_cp15_pkg.sv | 50 +++++
 rtl/arm7tdmi_cp15_if.sv | 29 ++
 rtl/arm7tdmi_cp15_regs.sv | 94 +++++++++
 rtl/arm7tdmi_cp15.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arm7tdmi_cp15_pkg.sv
// Shared types and constants for the CP15 system-control coprocessor.
// ARM7TDMI_CP15_FAULT_REGS_EN adds the c5/c6 fault registers to the implemented CRn set.
package arm7tdmi_cp15_pkg;

  typedef enum logic [2:0] {
    CP_MRC = 3'd0,
    CP_MCR = 3'd1,
    CP_CDP = 3'd2,
    CP_LDC = 3'd3,
    CP_STC = 3'd4
  } cp_op_t;

  typedef enum logic [1:0] {
    CP15_IDLE = 2'd0,
    CP15_BUSY = 2'd1,
    CP15_RESP = 2'd2
  } cp15_state_t;

  localparam logic [3:0] CP15_NUM       = 4'd15;
  localparam logic [3:0] CP15_C0_ID     = 4'd0;
  localparam logic [3:0] CP15_C1_CTRL   = 4'd1;
  localparam logic [3:0] CP15_C2_TTB    = 4'd2;
  localparam logic [3:0] CP15_C3_DOMAIN = 4'd3;
  localparam logic [3:0] CP15_C5_FSR    = 4'd5;
  localparam logic [3:0] CP15_C6_FAR    = 4'd6;
  localparam logic [3:0] CP15_C7_CACHE  = 4'd7;
  localparam logic [3:0] CP15_C8_TLB    = 4'd8;

  localparam logic [31:0] CP15_CTRL_WMASK = 32'h0000_2087;
  localparam logic [31:0] CP15_CTRL_RAO   = 32'h0000_0078;

  function automatic logic cp15_crn_implemented(input logic [3:0] crn);
    logic impl;
    case (crn)
      CP15_C0_ID, CP15_C1_CTRL, CP15_C2_TTB, CP15_C3_DOMAIN,
      CP15_C7_CACHE, CP15_C8_TLB: impl = 1'b1;
`ifdef ARM7TDMI_CP15_FAULT_REGS_EN
      CP15_C5_FSR, CP15_C6_FAR:   impl = 1'b1;
`endif
      default:                    impl = 1'b0;
    endcase
    return impl;
  endfunction

  // Cache/TLB maintenance registers: write-only, stall for a while, hold no state.
  function automatic logic cp15_is_maint(input logic [3:0] crn);
    return (crn == CP15_C7_CACHE) || (crn == CP15_C8_TLB);
  endfunction

endpackage

// File: rtl/arm7tdmi_cp15_if.sv
// Core-to-coprocessor request/response bus; the core is master, CP15 is slave.
import arm7tdmi_cp15_pkg::*;

interface arm7tdmi_cp15_if;
  logic        cp_req;
  cp_op_t      cp_op;
  logic [3:0]  cp_num;
  logic [3:0]  cp_crn;
  logic [3:0]  cp_crm;
  logic [2:0]  cp_opcode1;
  logic [2:0]  cp_opcode2;
  logic [31:0] cp_wdata;
  logic        cp_cancel;
  logic        cp_ready;
  logic        cp_busy;
  logic        cp_done;
  logic        cp_absent;
  logic [31:0] cp_rdata;

  modport master (
    output cp_req, cp_op, cp_num, cp_crn, cp_crm, cp_opcode1, cp_opcode2, cp_wdata, cp_cancel,
    input  cp_ready, cp_busy, cp_done, cp_absent, cp_rdata
  );

  modport slave (
    input  cp_req, cp_op, cp_num, cp_crn, cp_crm, cp_opcode1, cp_opcode2, cp_wdata, cp_cancel,
    output cp_ready, cp_busy, cp_done, cp_absent, cp_rdata
  );
endinterface

// File: rtl/arm7tdmi_cp15_regs.sv
// CP15 register file: control, translation base, domain and (with
// ARM7TDMI_CP15_FAULT_REGS_EN) the FSR/FAR fault registers.
import arm7tdmi_cp15_pkg::*;

module arm7tdmi_cp15_regs #(
  parameter logic [31:0] ID_VALUE = 32'h4100_7700
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  widx,
  input  logic [31:0] wdata,
  input  logic [3:0]  ridx,
  output logic [31:0] rd_data,
  output logic        ctrl_mmu_en,
  output logic        ctrl_align_en,
  output logic        ctrl_cache_en,
  output logic        ctrl_big_endian,
  output logic        ctrl_high_vec,
  output logic [17:0] ttb_base,
  output logic [31:0] domain_ac,
  input  logic        fault_valid,
  input  logic [7:0]  fault_status,
  input  logic [31:0] fault_addr
);

  logic [31:0] ctrl_r;
  logic [17:0] ttb_r;
  logic [31:0] dom_r;

  // Architectural c1/c2/c3 state, written on the commit edge of an MCR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= 32'h0;
      ttb_r  <= 18'h0;
      dom_r  <= 32'h0;
    end else if (we) begin
      case (widx)
        CP15_C1_CTRL:   ctrl_r <= wdata & CP15_CTRL_WMASK;
        CP15_C2_TTB:    ttb_r  <= wdata[31:14];
        CP15_C3_DOMAIN: dom_r  <= wdata;
        default:        ;
      endcase
    end
  end

`ifdef ARM7TDMI_CP15_FAULT_REGS_EN
  logic [7:0]  fsr_r;
  logic [31:0] far_r;

  // Fault capture; a hardware fault report beats a coincident software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsr_r <= 8'h0;
      far_r <= 32'h0;
    end else if (fault_valid) begin
      fsr_r <= fault_status;
      far_r <= fault_addr;
    end else if (we && (widx == CP15_C5_FSR)) begin
      fsr_r <= wdata[7:0];
    end else if (we && (widx == CP15_C6_FAR)) begin
      far_r <= wdata;
    end
  end
`else
  logic unused_fault_s;
  assign unused_fault_s = ^{fault_valid, fault_status, fault_addr};
`endif

  // MRC read mux.
  always_comb begin
    rd_data = 32'h0;
    case (ridx)
      CP15_C0_ID:     rd_data = ID_VALUE;
      CP15_C1_CTRL:   rd_data = ctrl_r | CP15_CTRL_RAO;
      CP15_C2_TTB:    rd_data = {ttb_r, 14'h0};
      CP15_C3_DOMAIN: rd_data = dom_r;
`ifdef ARM7TDMI_CP15_FAULT_REGS_EN
      CP15_C5_FSR:    rd_data = {24'h0, fsr_r};
      CP15_C6_FAR:    rd_data = far_r;
`endif
      default:        rd_data = 32'h0;
    endcase
  end

  assign ctrl_mmu_en     = ctrl_r[0];
  assign ctrl_align_en   = ctrl_r[1];
  assign ctrl_cache_en   = ctrl_r[2];
  assign ctrl_big_endian = ctrl_r[7];
  assign ctrl_high_vec   = ctrl_r[13];
  assign ttb_base        = ttb_r;
  assign domain_ac       = dom_r;

endmodule

// File: rtl/arm7tdmi_cp15.sv
// CP15 responder: request FSM, maintenance busy counter and absent decode.
// Define ARM7TDMI_CP15_FAULT_REGS_EN to add the c5/c6 fault registers.
import arm7tdmi_cp15_pkg::*;

module arm7tdmi_cp15 #(
  parameter logic [31:0] ID_VALUE    = 32'h4100_7700,
  parameter int          BUSY_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  arm7tdmi_cp15_if.slave        cp,
  output logic                  ctrl_mmu_en,
  output logic                  ctrl_align_en,
  output logic                  ctrl_cache_en,
  output logic                  ctrl_big_endian,
  output logic                  ctrl_high_vec,
  output logic [17:0]           ttb_base,
  output logic [31:0]           domain_ac,
  input  logic                  fault_valid,
  input  logic [7:0]            fault_status,
  input  logic [31:0]           fault_addr
);

  localparam logic [3:0] BUSY_INIT = 4'(BUSY_CYCLES);

  cp15_state_t state_r, state_n;
  logic [3:0]  cnt_r, cnt_n;
  cp_op_t      op_r;
  logic [3:0]  crn_r;
  logic [31:0] wdata_r;
  logic        req_absent_r;

  logic        ready_r, busy_r, done_r, absent_r;
  logic        done_n, absent_n;
  logic [31:0] rdata_r, rdata_n;

  logic        accept_s, absent_s, maint_mcr_s, we_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  assign unused_s = ^{cp.cp_crm, cp.cp_opcode2};
  assign accept_s = (state_r == CP15_IDLE) && cp.cp_req;

  // Absent decode of the request currently on the bus.
  always_comb begin
    absent_s = 1'b0;
    if (cp.cp_num != CP15_NUM) begin
      absent_s = 1'b1;
    end else if ((cp.cp_op != CP_MRC) && (cp.cp_op != CP_MCR)) begin
      absent_s = 1'b1;
    end else if (cp.cp_opcode1 != 3'd0) begin
      absent_s = 1'b1;
    end else if (!cp15_crn_implemented(cp.cp_crn)) begin
      absent_s = 1'b1;
    end else if ((cp.cp_op == CP_MRC) && cp15_is_maint(cp.cp_crn)) begin
      absent_s = 1'b1;
    end else begin
      absent_s = 1'b0;
    end
  end

  assign maint_mcr_s = !absent_s && (cp.cp_op == CP_MCR) && cp15_is_maint(cp.cp_crn);
  assign we_s        = (state_r == CP15_RESP) && (op_r == CP_MCR) && !req_absent_r;

  // Next-state, counter and response decode.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    done_n   = 1'b0;
    absent_n = 1'b0;
    rdata_n  = 32'h0;
    case (state_r)
      CP15_IDLE: begin
        if (!accept_s) begin
          state_n = CP15_IDLE;
        end else if (absent_s) begin
          state_n  = CP15_RESP;
          absent_n = 1'b1;
        end else if (maint_mcr_s) begin
          state_n = CP15_BUSY;
          cnt_n   = BUSY_INIT;
        end else begin
          state_n = CP15_RESP;
          done_n  = 1'b1;
          if (cp.cp_op == CP_MRC) begin
            rdata_n = rd_data_s;
          end else begin
            rdata_n = 32'h0;
          end
        end
      end
      CP15_BUSY: begin
        if (cp.cp_cancel) begin
          state_n = CP15_IDLE;
        end else if (cnt_r == 4'd1) begin
          state_n = CP15_RESP;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_r - 4'd1;
        end
      end
      CP15_RESP: state_n = CP15_IDLE;
      default:   state_n = CP15_IDLE;
    endcase
  end

  // FSM state, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= CP15_IDLE;
      cnt_r    <= 4'd0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      absent_r <= 1'b0;
      rdata_r  <= 32'h0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      ready_r  <= (state_n == CP15_IDLE);
      busy_r   <= (state_n == CP15_BUSY);
      done_r   <= done_n;
      absent_r <= absent_n;
      rdata_r  <= rdata_n;
    end
  end

  // Request capture so the commit does not depend on the core holding the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r         <= CP_MRC;
      crn_r        <= 4'd0;
      wdata_r      <= 32'h0;
      req_absent_r <= 1'b0;
    end else if (accept_s) begin
      op_r         <= cp.cp_op;
      crn_r        <= cp.cp_crn;
      wdata_r      <= cp.cp_wdata;
      req_absent_r <= absent_s;
    end
  end

  assign cp.cp_ready  = ready_r;
  assign cp.cp_busy   = busy_r;
  assign cp.cp_done   = done_r;
  assign cp.cp_absent = absent_r;
  assign cp.cp_rdata  = rdata_r;

  arm7tdmi_cp15_regs #(.ID_VALUE(ID_VALUE)) u_regs (
    .clk             (clk),
    .rst_n           (rst_n),
    .we              (we_s),
    .widx            (crn_r),
    .wdata           (wdata_r),
    .ridx            (cp.cp_crn),
    .rd_data         (rd_data_s),
    .ctrl_mmu_en     (ctrl_mmu_en),
    .ctrl_align_en   (ctrl_align_en),
    .ctrl_cache_en   (ctrl_cache_en),
    .ctrl_big_endian (ctrl_big_endian),
    .ctrl_high_vec   (ctrl_high_vec),
    .ttb_base        (ttb_base),
    .domain_ac       (domain_ac),
    .fault_valid     (fault_valid),
    .fault_status    (fault_status),
    .fault_addr      (fault_addr)
  );

endmodule
